// File: rtl/rnn_weight_streamer.sv
// Writable ROWS x COLS weight store that replays one row
// as a valid/ready stream toward the MAC datapath.
module rnn_weight_streamer #(
  parameter int ROWS  = 4,
  parameter int COLS  = 32,
  parameter int WIDTH = 16,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [CW-1:0]    wr_col,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic             start,
  input  logic [RW-1:0]    row,
  output logic             busy,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [WIDTH-1:0] w_data,
  output logic [CW-1:0]    w_col,
  output logic             w_last,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [RW:0]   ROWS_L  = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_L  = (CW+1)'(COLS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          wr_err_q, wr_err_d;
  logic [WIDTH-1:0] mem_q [ROWS][COLS];
  logic [WIDTH-1:0] mem_d [ROWS][COLS];

  logic row_ok;
  logic wr_idx_ok;
  logic wr_hit;
  logic wr_ok;

  assign row_ok    = {1'b0, row} < ROWS_L;
  assign wr_idx_ok = ({1'b0, wr_row} < ROWS_L)
                   && ({1'b0, wr_col} < COLS_L);
  // The row being streamed is frozen so w_data cannot change under a beat
  assign wr_hit    = busy && (wr_row == row_q);
  assign wr_ok     = wr_en && wr_idx_ok && !wr_hit;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    wr_err_d = wr_en && !wr_ok;
    mem_d    = mem_q;
    if (wr_ok) mem_d[wr_row][wr_col] = wr_data;
    unique case (state_q)
      S_IDLE: begin
        if (start && row_ok) begin
          row_d   = row;
          col_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_ready) begin
          if (col_q == COL_MAX) begin
            col_d   = '0;
            state_d = S_DONE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wr_err_q <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem_q[r][c] <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wr_err_q <= wr_err_d;
      mem_q    <= mem_d;
    end
  end

  assign w_valid = (state_q == S_STREAM);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign wr_err  = wr_err_q;
  assign w_data  = w_valid ? mem_q[row_q][col_q] : '0;
  assign w_col   = w_valid ? col_q : '0;
  assign w_last  = w_valid && (col_q == COL_MAX);

endmodule

// File: tb/tb_rnn_weight_streamer.sv
// Scoreboard bench for rnn_weight_streamer: directed stimulus
// pushes expected beats, a negedge monitor pops and compares.
module tb_rnn_weight_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_row;
  logic [4:0]  wr_col;
  logic [15:0] wr_data;
  logic        wr_err;
  logic        start;
  logic [1:0]  row;
  logic        busy;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic [4:0]  w_col;
  logic        w_last;
  logic        done;

  rnn_weight_streamer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data),
    .wr_err(wr_err), .start(start),
    .row(row), .busy(busy),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_col(w_col),
    .w_last(w_last), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] mdl [4][32];
  logic [21:0] sb [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  logic        stall;
  logic [15:0] hold_d;
  logic [4:0]  hold_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_data", 32'(w_data), 32'(hold_d));
        chk("hold_col", 32'(w_col), 32'(hold_c));
      end
      if (w_valid && w_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got %h expected none",
                   w_data);
        end else begin
          chk("beat", {10'd0, w_data, w_col, w_last},
              {10'd0, sb.pop_front()});
        end
      end
      if (!w_valid) chk("wdata_idle", 32'(w_data), 32'd0);
      stall  = w_valid && !w_ready;
      hold_d = w_data;
      hold_c = w_col;
    end
  end

  task automatic wr(input int r, input int c,
                    input logic [15:0] d);
    wr_en   = 1'b1;
    wr_row  = r[1:0];
    wr_col  = c[4:0];
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_row(input int r);
    for (int c = 0; c < 32; c++)
      sb.push_back({mdl[r][c], c[4:0], c == 31});
    start = 1'b1;
    row   = r[1:0];
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input bit tog, output int k);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      w_ready = tog ? i[0] : 1'b1;
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
      @(posedge clk); #1;
    end
    w_ready = 1'b1;
    if (k == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int k;
  int nd;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_row = '0;
    wr_col = '0; wr_data = '0; start = 1'b0;
    row = '0; w_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(w_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(w_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) begin
        mdl[r][c] = 16'((r << 8) | c);
        wr(r, c, mdl[r][c]);
      end

    // row 2, ready always high
    start_row(2);
    chk("t1_first_valid", 32'(w_valid), 32'd1);
    wait_done(1'b0, k);
    chk("t1_done_cycle", 32'(k), 32'd33);
    @(posedge clk); #1;
    chk("t1_busy_low", 32'(busy), 32'd0);

    // row 1, ready toggling
    start_row(1);
    wait_done(1'b1, k);
    chk("t2_done_cycle", 32'(k), 32'd64);
    @(posedge clk); #1;

    // writes while streaming row 3
    w_ready = 1'b1;
    start_row(3);
    wr_en = 1'b1; wr_row = 2'd3;
    wr_col = 5'd5; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    chk("t3_err_hit", 32'(wr_err), 32'd1);
    wr_row = 2'd0; wr_col = 5'd0; wr_data = 16'h1234;
    mdl[0][0] = 16'h1234;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("t3_err_other", 32'(wr_err), 32'd0);
    @(posedge clk); #1;
    chk("t3_err_quiet", 32'(wr_err), 32'd0);
    wait_done(1'b0, k);
    @(posedge clk); #1;
    start_row(3);
    wait_done(1'b0, k);
    @(posedge clk); #1;
    start_row(0);
    wait_done(1'b0, k);
    @(posedge clk); #1;

    // start while busy is dropped
    start_row(0);
    repeat (5) begin
      start = 1'b1; row = 2'd2;
      @(posedge clk); #1;
    end
    start = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t4_one_done", 32'(nd), 32'd1);
    @(posedge clk); #1;
    chk("t4_idle", 32'(busy), 32'd0);
    wr_en = 1'b1; wr_row = 2'd1;
    wr_col = 5'd0; wr_data = 16'hFF93;
    mdl[1][0] = 16'hFF93;
    start_row(1);
    chk("t4_no_err", 32'(wr_err), 32'd0);
    wait_done(1'b0, k);
    chk("t4_done_cycle", 32'(k), 32'd33);
    @(posedge clk); #1;

    // asynchronous reset mid-stream
    start_row(0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(w_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_data", 32'(w_data), 32'd0);
    sb.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++)
        mdl[r][c] = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    start_row(0);
    wait_done(1'b0, k);
    chk("t5_done_cycle", 32'(k), 32'd33);
    @(posedge clk); #1;

    // top corner index accepted
    wr(3, 31, 16'h7FFF);
    mdl[3][31] = 16'h7FFF;
    chk("t6_no_err", 32'(wr_err), 32'd0);
    start_row(3);
    wait_done(1'b0, k);
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
